// File: rtl/irrigation_pkg.sv
// Shared types and output codes for the irrigation controller: sequencer states,
// valve-mode and cleaning-mode encodings used by the clock selector and display.
package irrigation_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_DRIP  = 3'd2,
        S_SPRAY = 3'd3,
        S_DRAIN = 3'd4,
        S_FLUSH = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam logic [1:0] REGA_OFF      = 2'b00;
    localparam logic [1:0] REGA_DRIP     = 2'b01;
    localparam logic [1:0] REGA_SPRAY    = 2'b10;

    localparam logic [1:0] LIMPEZA_OFF   = 2'b00;
    localparam logic [1:0] LIMPEZA_DRAIN = 2'b10;
    localparam logic [1:0] LIMPEZA_FLUSH = 2'b11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/irrigation_phase_timer.sv
// Slow-tick dwell counter: cleared on state change, advanced by tick, and
// flags the tick that completes a dwell of `limit` ticks.
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    assign done = en && (count == limit - 1'b1);

endmodule

// File: rtl/irrigation_sequencer.sv
// Irrigation mode sequencer: tank fill, drip/sprinkler runs, two-phase cleaning
// and sensor-fault handling. Optional macro FILL_TIMEOUT_EN bounds the FILL dwell.
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int DRIP_TICKS   = 8,
    parameter int SPRAY_TICKS  = 4,
    parameter int DRAIN_TICKS  = 3,
    parameter int FLUSH_TICKS  = 2,
    parameter int CLEAN_EVERY  = 4,
    parameter int FILL_TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       nivel_l,
    input  logic       nivel_m,
    input  logic       nivel_h,
    input  logic       seco,
    input  logic       temp_alta,
    input  logic       limpeza_req,
    input  logic       erro_ack,
    output logic [1:0] rega,
    output logic [1:0] limpeza,
    output logic       erro,
    output logic       VE,
    output logic [2:0] estado
);

    localparam int MAX_TICKS = max_int(max_int(DRIP_TICKS, SPRAY_TICKS),
                                       max_int(max_int(DRAIN_TICKS, FLUSH_TICKS), FILL_TIMEOUT));
    localparam int TW = $clog2(MAX_TICKS) + 1;
    localparam int RW = $clog2(CLEAN_EVERY + 1);

    state_t          state, state_nxt;
    logic [RW-1:0]   runs;
    logic            pending;
    logic            fault;
    logic [TW-1:0]   limit;
    logic            done;
    logic            run_exit;
    logic            clean_done;

    // Level marks must be monotonic: a higher mark without the one below is a bad sensor.
    assign fault = (nivel_h && !nivel_m) || (nivel_m && !nivel_l);

    always_comb begin
        case (state)
            S_DRIP:  limit = TW'(DRIP_TICKS);
            S_SPRAY: limit = TW'(SPRAY_TICKS);
            S_DRAIN: limit = TW'(DRAIN_TICKS);
            S_FLUSH: limit = TW'(FLUSH_TICKS);
            default: limit = TW'(FILL_TIMEOUT);
        endcase
    end

    phase_timer #(.W(TW)) u_timer (
        .clock (clock),
        .reset (reset),
        .clr   (state_nxt != state),
        .en    (tick),
        .limit (limit),
        .done  (done)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        run_exit   = 1'b0;
        clean_done = 1'b0;
        rega       = REGA_OFF;
        limpeza    = LIMPEZA_OFF;
        erro       = 1'b0;
        VE         = 1'b0;

        case (state)
            S_IDLE: begin
                if (pending || runs == RW'(CLEAN_EVERY)) state_nxt = S_DRAIN;
                else if (!nivel_l)                       state_nxt = S_FILL;
                else if (seco && temp_alta)              state_nxt = S_SPRAY;
                else if (seco)                           state_nxt = S_DRIP;
            end
            S_FILL: begin
                VE = 1'b1;
                if (nivel_h) state_nxt = S_IDLE;
`ifdef FILL_TIMEOUT_EN
                else if (done) state_nxt = S_ERROR;
`endif
            end
            S_DRIP, S_SPRAY: begin
                rega = (state == S_DRIP) ? REGA_DRIP : REGA_SPRAY;
                if (!seco || !nivel_l || done) begin
                    state_nxt = S_IDLE;
                    run_exit  = 1'b1;
                end
            end
            S_DRAIN: begin
                limpeza = LIMPEZA_DRAIN;
                if (done) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                limpeza = LIMPEZA_FLUSH;
                VE      = 1'b1;
                if (done) begin
                    state_nxt  = S_IDLE;
                    clean_done = 1'b1;
                end
            end
            S_ERROR: begin
                erro = 1'b1;
                if (erro_ack) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // A fault pre-empts every exit, so an interrupted run is not counted.
        if (fault) begin
            state_nxt  = S_ERROR;
            run_exit   = 1'b0;
            clean_done = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            runs    <= '0;
            pending <= 1'b0;
        end else begin
            if (clean_done)
                runs <= '0;
            else if (run_exit && runs != RW'(CLEAN_EVERY))
                runs <= runs + 1'b1;

            if (clean_done)
                pending <= 1'b0;
            else if (limpeza_req && state != S_DRAIN && state != S_FLUSH)
                pending <= 1'b1;
        end
    end

    assign estado = state;

endmodule
